// File: rtl/hunt_round_ctrl.sv
// ============================================================================
// hunt_round_ctrl : duck-hunt round sequencer (state, bullets, hits, score)
// Revision 1.0
// ============================================================================
`default_nettype none

module hunt_round_ctrl #(
  parameter int READY_FRAMES    = 60,
  parameter int FLY_FRAMES      = 300,
  parameter int RESULT_FRAMES   = 90,
  parameter int DUCKS_PER_ROUND = 10,
  parameter int PASS_HITS       = 6,
  parameter int POINTS          = 500
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic        start,
  input  logic        trigger,
  input  logic        on_target,
  input  logic        flew_away,
  input  logic        bird_shot,
  output logic [1:0]  state,
  output logic        shot,
  output logic [1:0]  shots_left,
  output logic [3:0]  duck_num,
  output logic [3:0]  ducks_hit,
  output logic [6:0]  round,
  output logic [15:0] score,
  output logic        game_over
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_READY  = 2'b01;
  localparam logic [1:0] ST_FLYING = 2'b10;
  localparam logic [1:0] ST_RESULT = 2'b11;

  localparam logic [8:0]  READY_LAST  = 9'(READY_FRAMES - 1);
  localparam logic [8:0]  FLY_LAST    = 9'(FLY_FRAMES - 1);
  localparam logic [8:0]  RESULT_LAST = 9'(RESULT_FRAMES - 1);
  localparam logic [3:0]  DUCK_LAST   = 4'(DUCKS_PER_ROUND - 1);
  localparam logic [3:0]  PASS_MIN    = 4'(PASS_HITS);
  localparam logic [15:0] HIT_POINTS  = 16'(POINTS);
  localparam logic [6:0]  ROUND_MAX   = 7'd99;

  logic        frame_s0;
  logic        frame_s1;
  logic        frame_edge;
  logic [8:0]  fcnt;
  logic        shot_pending;
  logic [1:0]  state_next;
  logic        result_done;
  logic        round_passed;
  logic [16:0] score_sum;
  logic [15:0] score_hit;

  // frame_clk is only ever looked at through these two flops
  assign frame_edge   = frame_s0 & ~frame_s1;
  assign shot         = shot_pending;
  assign result_done  = frame_edge && (fcnt == RESULT_LAST);
  assign round_passed = ducks_hit >= PASS_MIN;
  assign score_sum    = {1'b0, score} + {1'b0, HIT_POINTS};
  assign score_hit    = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_READY;
      end
      ST_READY: begin
        if (frame_edge && (fcnt == READY_LAST)) state_next = ST_FLYING;
      end
      ST_FLYING: begin
        if (bird_shot || flew_away || (frame_edge && (fcnt == FLY_LAST)))
          state_next = ST_RESULT;
      end
      ST_RESULT: begin
        if (result_done) begin
          if ((duck_num < DUCK_LAST) || round_passed) state_next = ST_READY;
          else                                        state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= ST_IDLE;
      frame_s0     <= 1'b0;
      frame_s1     <= 1'b0;
      fcnt         <= 9'd0;
      shot_pending <= 1'b0;
      shots_left   <= 2'd0;
      duck_num     <= 4'd0;
      ducks_hit    <= 4'd0;
      round        <= 7'd0;
      score        <= 16'd0;
      game_over    <= 1'b0;
    end else begin
      state    <= state_next;
      frame_s0 <= frame_clk;
      frame_s1 <= frame_s0;

      if (state_next != state) fcnt <= 9'd0;
      else if (frame_edge)     fcnt <= fcnt + 9'd1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            score     <= 16'd0;
            ducks_hit <= 4'd0;
            duck_num  <= 4'd0;
            game_over <= 1'b0;
            round     <= 7'd1;
          end
        end
        ST_READY: begin
          if (state_next == ST_FLYING) shots_left <= 2'd3;
        end
        ST_FLYING: begin
          // shot is held through the next frame_edge cycle so the datapath sees it
          if (frame_edge) shot_pending <= 1'b0;
          if (trigger && (shots_left != 2'd0)) begin
            shots_left <= shots_left - 2'd1;
            if (on_target) shot_pending <= 1'b1;
          end
          if (bird_shot) begin
            ducks_hit <= ducks_hit + 4'd1;
            score     <= score_hit;
          end
          if (state_next == ST_RESULT) shot_pending <= 1'b0;
        end
        ST_RESULT: begin
          shot_pending <= 1'b0;
          if (result_done) begin
            if (duck_num < DUCK_LAST) begin
              duck_num <= duck_num + 4'd1;
            end else if (round_passed) begin
              round     <= (round >= ROUND_MAX) ? ROUND_MAX : round + 7'd1;
              duck_num  <= 4'd0;
              ducks_hit <= 4'd0;
            end else begin
              game_over <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/hunt_round_ctrl.md
HUNT_ROUND_CTRL -- requirements
Module: hunt_round_ctrl

Interface
REQ-001 Parameter READY_FRAMES, 60, frames spent in READY before the duck launches.
REQ-002 Parameter FLY_FRAMES, 300, maximum frames in FLYING before a forced miss.
REQ-003 Parameter RESULT_FRAMES, 90, frames spent in RESULT.
REQ-004 Parameter DUCKS_PER_ROUND, 10, ducks per round.
REQ-005 Parameter PASS_HITS, 6, minimum hits per round to advance.
REQ-006 Parameter POINTS, 500, score added per hit.
REQ-007 Port Clk, in, 1, 50 MHz system clock; the block has one clock.
REQ-008 Port Reset_n, in, 1, asynchronous, active-low reset.
REQ-009 Port frame_clk, in, 1, frame strobe at ~60 Hz, asynchronous to Clk.
REQ-010 Port start, in, 1, single-Clk pulse that starts a game.
REQ-011 Port trigger, in, 1, single-Clk pulse for a gun trigger pull.
REQ-012 Port on_target, in, 1, gun sensor qualified against is_duck, sampled in the trigger cycle.
REQ-013 Port flew_away, in, 1, escape pulse from the duck datapath.
REQ-014 Port bird_shot, in, 1, hit pulse from the duck datapath.
REQ-015 Port state, out, 2, game state: IDLE=00, READY=01, FLYING=10, RESULT=11.
REQ-016 Port shot, out, 1, hit request to the duck datapath.
REQ-017 Port shots_left, out, 2, remaining bullets.
REQ-018 Port duck_num, out, 4, index of the current duck within the round.
REQ-019 Port ducks_hit, out, 4, hits in the current round.
REQ-020 Port round, out, 7, current round number.
REQ-021 Port score, out, 16, accumulated score.
REQ-022 Port game_over, out, 1, high while IDLE is entered after a failed round.

Function
REQ-023 The block SHALL detect frame edges with a two-flop scheme: frame_edge is asserted 1 Clk after frame_clk is sampled high following a low sample, and lasts exactly 1 Clk.
REQ-024 A frame counter, fcnt (9 bits), SHALL clear on every state change and increment on each frame_edge.
REQ-025 IDLE: on start, clear score, ducks_hit, duck_num and game_over; set round=1; go to READY.
REQ-026 READY: on the frame_edge at which fcnt reaches READY_FRAMES-1, set shots_left=3 and go to FLYING.
REQ-027 FLYING: a trigger with shots_left>0 SHALL decrement shots_left; a trigger with shots_left=0 SHALL be ignored.
REQ-028 FLYING: a trigger with on_target=1 and shots_left>0 SHALL set shot_pending.
REQ-029 shot SHALL equal shot_pending.
REQ-030 shot_pending SHALL clear on the Clk after a frame_edge, so shot is high during the frame_edge cycle.
REQ-031 Exit FLYING on bird_shot (hit): ducks_hit+1, score+POINTS saturating at 16'hFFFF, go to RESULT.
REQ-032 Exit FLYING on flew_away (miss): go to RESULT.
REQ-033 Exit FLYING on the frame_edge at which fcnt reaches FLY_FRAMES-1 (forced miss): go to RESULT.
REQ-034 In FLYING, priority SHALL be bird_shot > flew_away > timeout in the same cycle.
REQ-035 shots_left=0 SHALL NOT end FLYING; the duck continues until escape or timeout.
REQ-036 RESULT: shot_pending SHALL be cleared on entry.
REQ-037 RESULT: after RESULT_FRAMES frames, if duck_num<DUCKS_PER_ROUND-1, increment duck_num and go to READY.
REQ-038 RESULT, last duck, ducks_hit>=PASS_HITS: round+1 saturating at 99, clear duck_num and ducks_hit, go to READY.
REQ-039 RESULT, last duck, ducks_hit<PASS_HITS: set game_over=1, go to IDLE, and hold score and round.
REQ-040 trigger, start, flew_away and bird_shot SHALL be ignored in states where they are not listed above.

Reset
REQ-041 Reset_n low SHALL asynchronously force state=IDLE, shot=0, shot_pending=0, shots_left=0, duck_num=0, ducks_hit=0, round=0, score=0, game_over=0, fcnt=0 and the edge-detect flops to 0.
REQ-042 Reset_n low mid-operation SHALL abort immediately, and shot SHALL deassert in the same cycle.
REQ-043 After Reset_n goes high, the first state change SHALL occur only on start.

Verification
REQ-044 Start pulse, then 60 frame_clk edges -> state=10 on the 60th frame_edge, shots_left=3.
REQ-045 In FLYING, trigger with on_target=1 -> shots_left=2 and shot=1; shot is seen in the next frame_edge cycle and is 0 the cycle after; bird_shot then gives ducks_hit=1, score=500, state=11.
REQ-046 In FLYING, four triggers with on_target=0 -> shots_left goes 2,1,0,0 and shot is never 1; a flew_away pulse then gives state=11 with ducks_hit unchanged.
REQ-047 In FLYING, bird_shot and flew_away in the same cycle -> treated as a hit, ducks_hit+1.
REQ-048 10 ducks with 6 hits -> round=2, duck_num=0, state=01; 10 ducks with 5 hits -> state=00, game_over=1, score=2500.
REQ-049 Reset_n pulsed low while shot=1 in FLYING -> all outputs at reset values within the same cycle.
